// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, keeps up to two imem requests in flight and
// buffers returned words in a 2-entry FIFO whose head is presented to ID.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [2:0]  CREDITS = 3'(DEPTH);

    logic [31:0] pc_reg, pc_next;
    logic [31:0] resp_pc_reg, resp_pc_next;
    logic [1:0]  out_cnt_reg, out_cnt_next;
    logic [1:0]  kill_cnt_reg, kill_cnt_next;
    logic [1:0]  fifo_cnt_reg, fifo_cnt_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic        wr_ptr_reg, wr_ptr_next;
    logic [31:0] fifo_addr_reg [DEPTH];
    logic [31:0] fifo_inst_reg [DEPTH];

    logic        head_valid;
    logic        pop;
    logic        rsp;
    logic        push;
    logic        grant;
    logic [2:0]  credit_used;
    logic [31:0] jump_target;
    logic        jump_addr_unused;

    assign jump_target      = {jump_addr_i[31:2], 2'b00};
    assign jump_addr_unused = ^jump_addr_i[1:0];

    assign head_valid = (fifo_cnt_reg != 2'd0);
    assign pop        = head_valid & ~hold_i & ~jump_flag_i;
    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign rsp        = imem_rvalid_i & (out_cnt_reg != 2'd0);
    assign push       = rsp & ~jump_flag_i & (kill_cnt_reg == 2'd0);

    // Outstanding requests plus buffered words may never exceed the FIFO depth,
    // counting a word popped this cycle as already freed.
    assign credit_used = {1'b0, out_cnt_reg} + {1'b0, fifo_cnt_reg} - {2'b00, pop};
    assign imem_req_o  = rst_n & ~jump_flag_i & (credit_used < CREDITS);
    assign imem_addr_o = pc_reg;
    assign grant       = imem_req_o & imem_gnt_i;

    always_comb begin
        pc_next       = pc_reg;
        resp_pc_next  = resp_pc_reg;
        kill_cnt_next = kill_cnt_reg;
        fifo_cnt_next = fifo_cnt_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_ptr_next   = wr_ptr_reg;
        out_cnt_next  = out_cnt_reg + {1'b0, grant} - {1'b0, rsp};

        if (jump_flag_i) begin
            pc_next       = jump_target;
            resp_pc_next  = jump_target;
            // Everything still in flight after this cycle belongs to the old stream.
            kill_cnt_next = out_cnt_reg - {1'b0, rsp};
            fifo_cnt_next = 2'd0;
            rd_ptr_next   = 1'b0;
            wr_ptr_next   = 1'b0;
        end else begin
            if (grant) begin
                pc_next = pc_reg + 32'd4;
            end
            if (rsp && (kill_cnt_reg != 2'd0)) begin
                kill_cnt_next = kill_cnt_reg - 2'd1;
            end
            if (push) begin
                resp_pc_next = resp_pc_reg + 32'd4;
                wr_ptr_next  = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            fifo_cnt_next = fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            out_cnt_reg  <= 2'd0;
            kill_cnt_reg <= 2'd0;
            fifo_cnt_reg <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            resp_pc_reg  <= resp_pc_next;
            out_cnt_reg  <= out_cnt_next;
            kill_cnt_reg <= kill_cnt_next;
            fifo_cnt_reg <= fifo_cnt_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // Buffer payload needs no reset: it is only visible while fifo_cnt is non-zero.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == 1'(gi))) begin
                fifo_addr_reg[gi] <= resp_pc_reg;
                fifo_inst_reg[gi] <= imem_rdata_i;
            end
        end
    end

    assign inst_valid_o = head_valid;
    assign inst_o       = head_valid ? fifo_inst_reg[rd_ptr_reg] : NOP;
    assign inst_addr_o  = head_valid ? fifo_addr_reg[rd_ptr_reg] : 32'd0;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a memory model plus a scoreboard of expected fetch addresses,
// pushed on each grant and popped whenever ID consumes an instruction.
module tb_if_fetch;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;

    if_fetch #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .hold_i       (hold_i),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] sb_q[$];
    logic [31:0] exp_pc;
    int          checks = 0;
    int          failures = 0;
    int          gnt_delay = 0;
    int          gnt_wait = 0;
    int          gap_pct = 0;
    bit          resp_en = 1'b1;
    int          n_pops = 0;

    logic        s_req, s_gnt, s_rv, s_valid, s_hold, s_jump, s_pop;
    logic [31:0] s_addr, s_inst, s_iaddr, s_jaddr, s_pop_addr;
    int          s_credit;

    // addi x1, x0, imm with the immediate taken from the word address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[13:2], 5'd0, 3'd0, 5'd1, 7'h13};
    endfunction

    task automatic cycle();
        int          live;
        logic [31:0] e;
        @(negedge clk);
        if (resp_en && pend_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend_q[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'hdead_beef;
        end
        #1;
        imem_gnt_i = imem_req_o && (gnt_wait >= gnt_delay);
        #1;
        s_req   = imem_req_o;
        s_gnt   = imem_gnt_i;
        s_addr  = imem_addr_o;
        s_rv    = imem_rvalid_i;
        s_valid = inst_valid_o;
        s_inst  = inst_o;
        s_iaddr = inst_addr_o;
        s_hold  = hold_i;
        s_jump  = jump_flag_i;
        s_jaddr = jump_addr_i;
        live = 0;
        foreach (pend_q[i]) if (!pend_q[i].stale) live++;
        s_credit   = pend_q.size() + (sb_q.size() - live);
        s_pop      = s_valid && !s_hold && !s_jump;
        s_pop_addr = s_iaddr;
        if (!s_valid) begin
            checks++;
            if (s_inst !== NOP || s_iaddr !== 32'd0) begin
                failures++;
                $display("FAIL idle_outputs inst=%h addr=%h expected inst=%h addr=0", s_inst, s_iaddr, NOP);
            end
        end
        if (s_jump) begin
            checks++;
            if (s_req !== 1'b0) begin
                failures++;
                $display("FAIL req_during_jump req=%b expected 0", s_req);
            end
        end
        if (s_pop) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_inst addr=%h inst=%h expected nothing", s_iaddr, s_inst);
            end else begin
                e = sb_q.pop_front();
                n_pops++;
                if (s_iaddr !== e || s_inst !== mem_word(e)) begin
                    failures++;
                    $display("FAIL pop_order addr=%h inst=%h expected addr=%h inst=%h", s_iaddr, s_inst, e, mem_word(e));
                end
            end
        end
        @(posedge clk);
        #1;
        if (s_jump) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
            sb_q.delete();
            exp_pc = {s_jaddr[31:2], 2'b00};
        end
        if (s_rv) pend_q.delete(0);
        if (s_req && s_gnt) begin
            checks++;
            if (s_addr !== exp_pc) begin
                failures++;
                $display("FAIL fetch_addr addr=%h expected %h", s_addr, exp_pc);
            end
            pend_q.push_back('{s_addr, 1'b0});
            sb_q.push_back(exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
        gnt_wait = (s_req && !s_gnt) ? gnt_wait + 1 : 0;
    endtask

    task automatic fill_outstanding(input string name);
        resp_en = 1'b0;
        for (int k = 0; k < 10 && pend_q.size() < 2; k++) cycle();
        checks++;
        if (pend_q.size() != 2) begin
            failures++;
            $display("FAIL %s_setup outstanding=%0d expected 2", name, pend_q.size());
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (s_req !== 1'b0 || s_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_state req=%b valid=%b expected 0 0", s_req, s_valid);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 12; k++) begin
            cycle();
            checks++;
            if (s_req !== 1'b1 || s_addr !== RESET_PC + 32'(4 * k)) begin
                failures++;
                $display("FAIL stream_req cycle=%0d req=%b addr=%h expected 1 %h", k, s_req, s_addr, RESET_PC + 32'(4 * k));
            end
            checks++;
            if (s_valid !== (k >= 2)) begin
                failures++;
                $display("FAIL stream_valid cycle=%0d valid=%b expected %b", k, s_valid, (k >= 2));
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] held;
        hold_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k == 0) held = s_inst;
            checks++;
            if (s_req !== (s_credit < 2)) begin
                failures++;
                $display("FAIL hold_req cycle=%0d req=%b expected %b", k, s_req, (s_credit < 2));
            end
            checks++;
            if (s_inst !== held || s_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d inst=%h valid=%b expected %h 1", k, s_inst, s_valid, held);
            end
        end
        checks++;
        if (s_credit != 2) begin
            failures++;
            $display("FAIL hold_fill credits=%0d expected 2", s_credit);
        end
        hold_i = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
    endtask

    task automatic test_redirect();
        bit got;
        fill_outstanding("redirect");
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h8000_0103;
        cycle();
        jump_flag_i = 1'b0;
        jump_addr_i = 32'd0;
        resp_en     = 1'b1;
        cycle();
        checks++;
        if (s_valid !== 1'b0) begin
            failures++;
            $display("FAIL redirect_flush valid=%b expected 0", s_valid);
        end
        got = 1'b0;
        for (int k = 2; k < 16; k++) begin
            cycle();
            if (s_pop && !got) begin
                got = 1'b1;
                checks++;
                if (s_pop_addr !== 32'h8000_0100 || k < 3) begin
                    failures++;
                    $display("FAIL redirect_first addr=%h cycle=%0d expected 80000100 at cycle>=3", s_pop_addr, k);
                end
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL redirect_timeout valid=%b expected an instruction", s_valid);
        end
    endtask

    task automatic test_jump_rvalid_hold();
        bit got;
        fill_outstanding("jump_rvalid");
        hold_i      = 1'b1;
        resp_en     = 1'b1;
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h8000_0200;
        cycle();
        jump_flag_i = 1'b0;
        jump_addr_i = 32'd0;
        cycle();
        checks++;
        if (s_valid !== 1'b0) begin
            failures++;
            $display("FAIL jump_rvalid_flush valid=%b expected 0", s_valid);
        end
        hold_i = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (s_pop && !got) begin
                got = 1'b1;
                checks++;
                if (s_pop_addr !== 32'h8000_0200) begin
                    failures++;
                    $display("FAIL jump_rvalid_first addr=%h expected 80000200", s_pop_addr);
                end
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL jump_rvalid_timeout valid=%b expected an instruction", s_valid);
        end
    endtask

    task automatic test_random_memory();
        int start_pops;
        start_pops = n_pops;
        gnt_delay  = 3;
        gap_pct    = 40;
        for (int k = 0; k < 300; k++) begin
            hold_i = ($urandom_range(99) < 30);
            cycle();
            checks++;
            if (s_credit > 2) begin
                failures++;
                $display("FAIL credit_limit cycle=%0d used=%0d expected <=2", k, s_credit);
            end
        end
        hold_i    = 1'b0;
        gnt_delay = 0;
        gap_pct   = 0;
        for (int k = 0; k < 10; k++) cycle();
        checks++;
        if (n_pops - start_pops < 30) begin
            failures++;
            $display("FAIL random_progress consumed=%0d expected >=30", n_pops - start_pops);
        end
    endtask

    task automatic test_async_reset();
        fill_outstanding("async_reset");
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || inst_o !== NOP || inst_addr_o !== 32'd0) begin
            failures++;
            $display("FAIL async_reset req=%b valid=%b inst=%h addr=%h expected 0 0 %h 0", imem_req_o, inst_valid_o, inst_o, inst_addr_o, NOP);
        end
        pend_q.delete();
        sb_q.delete();
        exp_pc   = RESET_PC;
        gnt_wait = 0;
        resp_en  = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++;
            if (s_req !== 1'b0) begin
                failures++;
                $display("FAIL async_reset_req req=%b expected 0", s_req);
            end
        end
        rst_n = 1'b1;
        cycle();
        checks++;
        if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
            failures++;
            $display("FAIL restart req=%b addr=%h expected 1 %h", s_req, s_addr, RESET_PC);
        end
        for (int k = 0; k < 8; k++) cycle();
        checks++;
        if (s_valid !== 1'b1) begin
            failures++;
            $display("FAIL restart_stream valid=%b expected 1", s_valid);
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'd0;
        jump_flag_i   = 1'b0;
        jump_addr_i   = 32'd0;
        hold_i        = 1'b0;
        exp_pc        = RESET_PC;
        #2;
        rst_n = 1'b0;
        test_reset();
        test_stream();
        test_hold();
        test_redirect();
        test_jump_rvalid_hold();
        test_random_memory();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the core, directly upstream of the ID decoders. It owns the PC and issues in-order requests to the instruction memory port, keeping at most two requests outstanding. Returned words go into a 2-entry instruction buffer. The buffer head is presented to ID as `inst_o`/`inst_addr_o` with a valid flag. Branch/jump redirects from EX flush the buffer and discard in-flight responses.

## Interface
- `RESET_PC`, 32'h8000_0000, PC loaded on reset.
- `DEPTH`, 2, instruction buffer entries; also the credit limit for (outstanding + buffered). Only 2 is supported.

- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: fetch address, word aligned.
- `imem_gnt_i` in 1: memory accepted the request this cycle.
- `imem_rvalid_i` in 1: response valid, in request order, at most one per cycle.
- `imem_rdata_i` in 32: response instruction word.
- `jump_flag_i` in 1: redirect pulse from EX.
- `jump_addr_i` in 32: redirect target; bits [1:0] are ignored and treated as 00.
- `hold_i` in 1: pipeline stall; ID must not consume.
- `inst_valid_o` out 1: buffer head is valid.
- `inst_o` out 32: instruction to ID. Reads 32'h0000_0013 (NOP) when `inst_valid_o`=0.
- `inst_addr_o` out 32: PC of `inst_o`. Reads 0 when `inst_valid_o`=0.

## Operation
- State:
  - `pc`: next fetch address.
  - `resp_pc`: address of the next expected response.
  - `out_cnt` (0..2): outstanding requests, including ones marked for discard.
  - `kill_cnt` (0..2): responses to discard.
  - 2-entry FIFO of {addr, inst} with `fifo_cnt`.
- `pop` = `inst_valid_o` & ~`hold_i` & ~`jump_flag_i`.
- `imem_req_o` = ~`jump_flag_i` & (`out_cnt` + `fifo_cnt` − `pop` < 2). `imem_addr_o` = `pc`.
- Grant (`imem_req_o` & `imem_gnt_i`): `pc` <= `pc`+4 (wraps mod 2^32); `out_cnt`++.
- Response (`imem_rvalid_i`): `out_cnt`--.
  - If `kill_cnt`>0: drop the data and decrement `kill_cnt`.
  - Else: push {`resp_pc`, `imem_rdata_i`} and set `resp_pc` += 4.
- Grant and response in the same cycle: `out_cnt` is unchanged.
- Response with `out_cnt`=0 is a protocol error and is ignored; the counter does not underflow.
- Credits guarantee the FIFO never overflows. Push and pop in the same cycle leaves `fifo_cnt` unchanged.
- Redirect (`jump_flag_i`=1) has priority over everything else:
  - FIFO cleared; `fifo_cnt` <= 0.
  - `pc` and `resp_pc` <= {`jump_addr_i`[31:2], 2'b00}.
  - No request is issued this cycle.
  - `kill_cnt` <= `out_cnt` − `imem_rvalid_i`; any response arriving this cycle is itself dropped.
- Back-to-back redirects: the latest one wins; `kill_cnt` is recomputed from `out_cnt` each time.
- `hold_i` only blocks `pop`. Fetching continues until credits are exhausted.
- Reset values:
  - State: `pc`=`resp_pc`=`RESET_PC`; `out_cnt`=`kill_cnt`=`fifo_cnt`=0.
  - Outputs: `inst_valid_o`=0, `inst_o`=NOP, `inst_addr_o`=0.
  - `imem_req_o` is forced 0 while `rst_n`=0.
  - Reset mid-transaction abandons all outstanding responses. The memory side must also be reset.

## Timing
- First request is in the first cycle after `rst_n` rises, at `RESET_PC`.
- Latency: a response in cycle t is visible on `inst_o` in cycle t+1, because the FIFO is registered.
- With a zero-wait memory (grant same cycle, `rvalid` next cycle) and no hold, the stage sustains one instruction per cycle.
  - First instruction reaches `inst_valid_o` 2 cycles after the first request.
- Redirect in cycle t:
  - `inst_valid_o`=0 in t+1.
  - First target request in t+1.
  - Target instruction is valid no earlier than t+3.
- `imem_req_o` is combinational from registered state, `hold_i` and `jump_flag_i`. It must not depend on `imem_gnt_i`.

## Test plan
- Reset release, zero-wait memory returning `addi` words:
  - `imem_addr_o` = 8000_0000, 8000_0004, 8000_0008… on consecutive cycles.
  - `inst_valid_o`=1 from cycle 2.
  - `inst_addr_o` increments by 4 every cycle.
- `hold_i`=1 for 5 cycles mid-stream:
  - FIFO fills to 2; `imem_req_o` drops once out+fifo=2.
  - `inst_o` is stable during hold.
  - No instruction is lost or duplicated on release.
- Redirect with 2 outstanding:
  - `jump_flag_i`, `jump_addr_i`=8000_0103. Next fetch is at 8000_0100.
  - Both stale responses are dropped.
  - First valid `inst_addr_o`=8000_0100.
- Redirect in the same cycle as `imem_rvalid_i` and `hold_i`=1: the response is dropped, the FIFO empties, and `kill_cnt` = `out_cnt`−1.
- Memory with 3-cycle grant delay and random `rvalid` gaps: `inst_addr_o` sequence is strictly +4, and `out_cnt`+`fifo_cnt` never exceeds 2.
- `rst_n` pulled low while `out_cnt`=2: all outputs return to reset values asynchronously, and fetch restarts at `RESET_PC`.
